gpr_write_arbiter: RTL and testbench

Arbitrates write-back into the six 20-bit general-purpose registers between two requesters, the ALU result path and the memory load path. It grants one write per cycle using round-robin priority and issues a registered write port to the register file. It applies half-word masking, reports same-register collisions and illegal indices, and freezes writes while a trap is taken. It sits between the execute/memory stages and the general-purpose register storage.

---
 rtl/gpr_write_arbiter_pkg.sv | 29 ++
 rtl/gpr_write_arbiter_if.sv | 48 ++++
 rtl/gpr_write_arbiter_rr_arbiter2.sv | 47 ++++
 rtl/gpr_write_arbiter.sv | 161 ++++++++++++++++
 tb/tb_gpr_write_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/gpr_write_arbiter_pkg.sv
// Shared types, widths and helpers for the GPR write-back arbiter.
package gpr_arb_pkg;

   localparam int DATA_W   = 20;
   localparam int HALF_W   = 10;
   localparam int IDX_W    = 3;
   localparam int NUM_REGS = 6;

   localparam logic [DATA_W-1:0] FULL_MASK = 20'hFFFFF;
   localparam logic [DATA_W-1:0] HALF_MASK = 20'h003FF;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      TRAP  = 2'd2
   } arb_state_e;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_MEM = 1'b1
   } req_e;

   // Register index 0 is reserved and anything above the last GPR is illegal.
   function automatic logic idx_legal(input logic [IDX_W-1:0] idx,
                                      input logic [IDX_W-1:0] max_idx);
      return (idx != {IDX_W{1'b0}}) && (idx <= max_idx);
   endfunction

endpackage

// File: rtl/gpr_write_arbiter_if.sv
// Requester handshakes, trap controls and register-file write port of the arbiter.
interface gpr_write_arbiter_if #(
   parameter int DATA_W = gpr_arb_pkg::DATA_W,
   parameter int IDX_W  = gpr_arb_pkg::IDX_W
);
   logic              alu_valid;
   logic              alu_ready;
   logic [IDX_W-1:0]  alu_idx;
   logic [DATA_W-1:0] alu_data;
   logic              alu_half;

   logic              mem_valid;
   logic              mem_ready;
   logic [IDX_W-1:0]  mem_idx;
   logic [DATA_W-1:0] mem_data;
   logic              mem_half;

   logic              trap_req;
   logic              trap_clear;

   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] wr_mask;
   logic              same_register_flag;
   logic              index_error;
   logic              trap_mode;

   // Pipeline side: drives requests and trap controls, observes grants and the write port.
   modport master (
      output alu_valid, alu_idx, alu_data, alu_half,
      output mem_valid, mem_idx, mem_data, mem_half,
      output trap_req, trap_clear,
      input  alu_ready, mem_ready,
      input  wr_en, wr_idx, wr_data, wr_mask,
      input  same_register_flag, index_error, trap_mode
   );

   // Arbiter side.
   modport slave (
      input  alu_valid, alu_idx, alu_data, alu_half,
      input  mem_valid, mem_idx, mem_data, mem_half,
      input  trap_req, trap_clear,
      output alu_ready, mem_ready,
      output wr_en, wr_idx, wr_data, wr_mask,
      output same_register_flag, index_error, trap_mode
   );
endinterface

// File: rtl/gpr_write_arbiter_rr_arbiter2.sv
// Two-input round-robin grant; priority flips to the other input after every grant.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic [1:0] req_i,   // [0] = ALU, [1] = MEM
   output logic [1:0] gnt_o
);
   import gpr_arb_pkg::*;

   req_e prio_q;
   req_e prio_d;

   // Grant: the lone requester wins, otherwise the priority holder wins.
   always_comb begin
      gnt_o = 2'b00;
      if (!en_i) begin
         gnt_o = 2'b00;
      end else if (req_i == 2'b11) begin
         gnt_o = (prio_q == REQ_ALU) ? 2'b01 : 2'b10;
      end else begin
         gnt_o = req_i;
      end
   end

   // Priority moves away from whoever was just served.
   always_comb begin
      prio_d = prio_q;
      if (gnt_o[0]) begin
         prio_d = REQ_MEM;
      end else if (gnt_o[1]) begin
         prio_d = REQ_ALU;
      end else begin
         prio_d = prio_q;
      end
   end

   // Priority register, ALU first out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q <= REQ_ALU;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

// File: rtl/gpr_write_arbiter.sv
// GPR write-back arbiter: ALU vs memory-load round robin, trap freeze FSM and
// a registered register-file write port with half-word masking and error flags.
module gpr_write_arbiter #(
   parameter int DATA_W   = gpr_arb_pkg::DATA_W,
   parameter int NUM_REGS = gpr_arb_pkg::NUM_REGS,
   parameter int IDX_W    = gpr_arb_pkg::IDX_W
) (
   input logic                 clk,
   input logic                 rst_n,
   gpr_write_arbiter_if.slave  bus
);
   import gpr_arb_pkg::*;

   localparam logic [IDX_W-1:0]  MAX_IDX   = IDX_W'(NUM_REGS);
   localparam logic [DATA_W-1:0] MASK_FULL = DATA_W'(FULL_MASK);
   localparam logic [DATA_W-1:0] MASK_HALF = DATA_W'(HALF_MASK);

   arb_state_e        state_q, state_d;
   logic              arb_en_s;
   logic [1:0]        gnt_s;
   logic              sel_any_s;
   logic [IDX_W-1:0]  sel_idx_s;
   logic [DATA_W-1:0] sel_data_s;
   logic              sel_half_s;
   logic              sel_legal_s;

   logic              wr_en_q, wr_en_d;
   logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [DATA_W-1:0] wr_mask_q, wr_mask_d;
   logic              same_q, same_d;
   logic              idx_err_q, idx_err_d;
   logic              trap_mode_q, trap_mode_d;

   // Writes are only accepted in RUN and never in the cycle a trap is requested.
   assign arb_en_s = (state_q == RUN) && !bus.trap_req;

   rr_arbiter2 u_rr (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (arb_en_s),
      .req_i ({bus.mem_valid, bus.alu_valid}),
      .gnt_o (gnt_s)
   );

   assign bus.alu_ready = gnt_s[0];
   assign bus.mem_ready = gnt_s[1];

   // Trap FSM next state: DRAIN lets the last accepted write leave before TRAP.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (bus.trap_req) begin
               state_d = DRAIN;
            end else begin
               state_d = RUN;
            end
         end
         DRAIN: begin
            state_d = TRAP;
         end
         TRAP: begin
            if (bus.trap_clear && !bus.trap_req) begin
               state_d = RUN;
            end else begin
               state_d = TRAP;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // Payload of the granted requester.
   always_comb begin
      sel_any_s  = 1'b0;
      sel_idx_s  = {IDX_W{1'b0}};
      sel_data_s = {DATA_W{1'b0}};
      sel_half_s = 1'b0;
      if (gnt_s[0]) begin
         sel_any_s  = 1'b1;
         sel_idx_s  = bus.alu_idx;
         sel_data_s = bus.alu_data;
         sel_half_s = bus.alu_half;
      end else if (gnt_s[1]) begin
         sel_any_s  = 1'b1;
         sel_idx_s  = bus.mem_idx;
         sel_data_s = bus.mem_data;
         sel_half_s = bus.mem_half;
      end else begin
         sel_any_s  = 1'b0;
      end
   end

   assign sel_legal_s = idx_legal(sel_idx_s, MAX_IDX);

   // Next write-port and flag values; illegal targets complete the handshake but never write.
   always_comb begin
      wr_en_d     = sel_any_s && sel_legal_s;
      wr_idx_d    = {IDX_W{1'b0}};
      wr_data_d   = {DATA_W{1'b0}};
      wr_mask_d   = {DATA_W{1'b0}};
      idx_err_d   = sel_any_s && !sel_legal_s;
      same_d      = (state_q == RUN) && bus.alu_valid && bus.mem_valid &&
                    (bus.alu_idx == bus.mem_idx) && idx_legal(bus.alu_idx, MAX_IDX);
      trap_mode_d = (state_d == TRAP);
      if (wr_en_d) begin
         wr_idx_d = sel_idx_s;
         if (sel_half_s) begin
            wr_data_d = sel_data_s & MASK_HALF;
            wr_mask_d = MASK_HALF;
         end else begin
            wr_data_d = sel_data_s;
            wr_mask_d = MASK_FULL;
         end
      end else begin
         wr_idx_d  = {IDX_W{1'b0}};
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Registered write port and one-cycle status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en_q     <= 1'b0;
         wr_idx_q    <= {IDX_W{1'b0}};
         wr_data_q   <= {DATA_W{1'b0}};
         wr_mask_q   <= {DATA_W{1'b0}};
         same_q      <= 1'b0;
         idx_err_q   <= 1'b0;
         trap_mode_q <= 1'b0;
      end else begin
         wr_en_q     <= wr_en_d;
         wr_idx_q    <= wr_idx_d;
         wr_data_q   <= wr_data_d;
         wr_mask_q   <= wr_mask_d;
         same_q      <= same_d;
         idx_err_q   <= idx_err_d;
         trap_mode_q <= trap_mode_d;
      end
   end

   assign bus.wr_en              = wr_en_q;
   assign bus.wr_idx             = wr_idx_q;
   assign bus.wr_data            = wr_data_q;
   assign bus.wr_mask            = wr_mask_q;
   assign bus.same_register_flag = same_q;
   assign bus.index_error        = idx_err_q;
   assign bus.trap_mode          = trap_mode_q;

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// Scoreboard bench for gpr_write_arbiter: each driven cycle pushes the expected
// next-cycle write port / flags, a negedge monitor pops and compares them.
module tb_gpr_write_arbiter;
   import gpr_arb_pkg::*;

   typedef struct {
      logic              wr_en;
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
      logic [DATA_W-1:0] mask;
      logic              err;
      logic              same;
      logic              tmode;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   gpr_write_arbiter_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

   gpr_write_arbiter #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t       sb_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   arb_state_e st_m    = RUN;
   req_e       prio_m  = REQ_ALU;
   logic       ar_s, mr_s;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic tb_legal(input logic [IDX_W-1:0] i);
      return (int'(i) >= 1) && (int'(i) <= NUM_REGS);
   endfunction

   // Monitor: compare what the DUT presents this cycle against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("wr_en", 32'(bus.wr_en), 32'(e.wr_en));
            if (e.wr_en) begin
               check_eq("wr_idx",  32'(bus.wr_idx),  32'(e.idx));
               check_eq("wr_data", 32'(bus.wr_data), 32'(e.data));
               check_eq("wr_mask", 32'(bus.wr_mask), 32'(e.mask));
            end
            check_eq("index_error", 32'(bus.index_error),        32'(e.err));
            check_eq("same_reg",    32'(bus.same_register_flag), 32'(e.same));
            check_eq("trap_mode",   32'(bus.trap_mode),          32'(e.tmode));
         end else begin
            check_eq("wr_unexpected", 32'(bus.wr_en), 32'd0);
         end
      end
   end

   // One clock of stimulus: drive, check readies against the model, queue the expected outputs.
   task automatic step(input logic av, input logic [IDX_W-1:0] ai, input logic [DATA_W-1:0] ad,
                       input logic ah, input logic mv, input logic [IDX_W-1:0] mi,
                       input logic [DATA_W-1:0] md, input logic mh, input logic tr, input logic tc,
                       output logic ar, output logic mr);
      exp_t              e;
      logic              en, ga, gm, sh;
      logic [IDX_W-1:0]  si;
      logic [DATA_W-1:0] sd;
      bus.alu_valid = av; bus.alu_idx = ai; bus.alu_data = ad; bus.alu_half = ah;
      bus.mem_valid = mv; bus.mem_idx = mi; bus.mem_data = md; bus.mem_half = mh;
      bus.trap_req  = tr; bus.trap_clear = tc;
      @(negedge clk);
      en = (st_m == RUN) && !tr;
      ga = en && av && (!mv || prio_m == REQ_ALU);
      gm = en && mv && (!av || prio_m == REQ_MEM);
      ar = bus.alu_ready;
      mr = bus.mem_ready;
      check_eq("alu_ready", 32'(ar), 32'(ga));
      check_eq("mem_ready", 32'(mr), 32'(gm));
      si = gm ? mi : ai;
      sd = gm ? md : ad;
      sh = gm ? mh : ah;
      e.wr_en = (ga || gm) && tb_legal(si);
      e.idx   = si;
      e.data  = sh ? (sd & HALF_MASK) : sd;
      e.mask  = sh ? HALF_MASK : FULL_MASK;
      e.err   = (ga || gm) && !tb_legal(si);
      e.same  = (st_m == RUN) && av && mv && (ai == mi) && tb_legal(ai);
      if (ga) prio_m = REQ_MEM;
      else if (gm) prio_m = REQ_ALU;
      case (st_m)
         RUN:     if (tr) st_m = DRAIN;
         DRAIN:   st_m = TRAP;
         TRAP:    if (tc && !tr) st_m = RUN;
         default: st_m = RUN;
      endcase
      e.tmode = (st_m == TRAP);
      @(posedge clk);
      sb_q.push_back(e);
      #1;
   endtask

   task automatic idle_step(input logic tr, input logic tc);
      logic a, m;
      step(1'b0, 3'd0, 20'h0, 1'b0, 1'b0, 3'd0, 20'h0, 1'b0, tr, tc, a, m);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      bus.alu_valid = 1'b0; bus.alu_idx = 3'd0; bus.alu_data = 20'h0; bus.alu_half = 1'b0;
      bus.mem_valid = 1'b0; bus.mem_idx = 3'd0; bus.mem_data = 20'h0; bus.mem_half = 1'b0;
      bus.trap_req  = 1'b0; bus.trap_clear = 1'b0;
      sb_q.delete();
      st_m   = RUN;
      prio_m = REQ_ALU;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_wr_en",     32'(bus.wr_en),              32'd0);
      check_eq("rst_wr_idx",    32'(bus.wr_idx),             32'd0);
      check_eq("rst_wr_data",   32'(bus.wr_data),            32'd0);
      check_eq("rst_wr_mask",   32'(bus.wr_mask),            32'd0);
      check_eq("rst_same",      32'(bus.same_register_flag), 32'd0);
      check_eq("rst_idx_err",   32'(bus.index_error),        32'd0);
      check_eq("rst_trap_mode", 32'(bus.trap_mode),          32'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      apply_reset();

      // ALU only, full word.
      step(1'b1, 3'd3, 20'hABCDE, 1'b0, 1'b0, 3'd0, 20'h0, 1'b0, 1'b0, 1'b0, ar_s, mr_s);
      check_eq("t1_alu_ready", 32'(ar_s), 32'd1);
      check_eq("t1_wr_idx",    32'(bus.wr_idx),  32'd3);
      check_eq("t1_wr_mask",   32'(bus.wr_mask), 32'hFFFFF);
      idle_step(1'b0, 1'b0);

      // Both valid every cycle on distinct targets: strict alternation from reset.
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 3'd2, 20'h00100 + 20'(i), 1'b0, 1'b1, 3'd5, 20'h00200 + 20'(i), 1'b0,
              1'b0, 1'b0, ar_s, mr_s);
         check_eq("alt_alu", 32'(ar_s), (i % 2 == 0) ? 32'd1 : 32'd0);
         check_eq("alt_mem", 32'(mr_s), (i % 2 == 1) ? 32'd1 : 32'd0);
      end
      idle_step(1'b0, 1'b0);

      // Same target on both: one collision pulse, ALU first, MEM afterwards.
      step(1'b1, 3'd4, 20'h11111, 1'b0, 1'b1, 3'd4, 20'h22222, 1'b0, 1'b0, 1'b0, ar_s, mr_s);
      check_eq("col_alu_first", 32'(ar_s), 32'd1);
      check_eq("col_flag",      32'(bus.same_register_flag), 32'd1);
      check_eq("col_alu_data",  32'(bus.wr_data), 32'h11111);
      step(1'b0, 3'd0, 20'h0, 1'b0, 1'b1, 3'd4, 20'h22222, 1'b0, 1'b0, 1'b0, ar_s, mr_s);
      check_eq("col_mem_later", 32'(mr_s), 32'd1);
      check_eq("col_flag_once", 32'(bus.same_register_flag), 32'd0);
      check_eq("col_mem_data",  32'(bus.wr_data), 32'h22222);
      idle_step(1'b0, 1'b0);

      // Half-word load, then illegal indices 7 and 0.
      step(1'b0, 3'd0, 20'h0, 1'b0, 1'b1, 3'd1, 20'hFFFFF, 1'b1, 1'b0, 1'b0, ar_s, mr_s);
      check_eq("half_data", 32'(bus.wr_data), 32'h003FF);
      check_eq("half_mask", 32'(bus.wr_mask), 32'h003FF);
      step(1'b1, 3'd7, 20'h12345, 1'b0, 1'b0, 3'd0, 20'h0, 1'b0, 1'b0, 1'b0, ar_s, mr_s);
      check_eq("idx7_ready", 32'(ar_s), 32'd1);
      check_eq("idx7_no_wr", 32'(bus.wr_en), 32'd0);
      check_eq("idx7_err",   32'(bus.index_error), 32'd1);
      step(1'b1, 3'd0, 20'h54321, 1'b0, 1'b0, 3'd0, 20'h0, 1'b0, 1'b0, 1'b1, ar_s, mr_s);
      check_eq("idx0_err",   32'(bus.index_error), 32'd1);
      idle_step(1'b0, 1'b0);
      check_eq("err_pulse_end", 32'(bus.index_error), 32'd0);

      // Trap entry with a held ALU request, hold on req+clear, exit and serve the request.
      step(1'b1, 3'd2, 20'h12345, 1'b0, 1'b0, 3'd0, 20'h0, 1'b0, 1'b0, 1'b0, ar_s, mr_s);
      step(1'b1, 3'd5, 20'h05555, 1'b0, 1'b0, 3'd0, 20'h0, 1'b0, 1'b1, 1'b0, ar_s, mr_s);
      check_eq("trap_req_blocks", 32'(ar_s), 32'd0);
      check_eq("pre_trap_write",  32'(bus.wr_en), 32'd0);
      step(1'b1, 3'd5, 20'h05555, 1'b0, 1'b0, 3'd0, 20'h0, 1'b0, 1'b1, 1'b0, ar_s, mr_s);
      check_eq("trap_entered", 32'(bus.trap_mode), 32'd1);
      step(1'b1, 3'd5, 20'h05555, 1'b0, 1'b0, 3'd0, 20'h0, 1'b0, 1'b1, 1'b1, ar_s, mr_s);
      check_eq("trap_both_hold", 32'(bus.trap_mode), 32'd1);
      step(1'b1, 3'd5, 20'h05555, 1'b0, 1'b0, 3'd0, 20'h0, 1'b0, 1'b0, 1'b0, ar_s, mr_s);
      check_eq("trap_ready_low", 32'(ar_s), 32'd0);
      step(1'b1, 3'd5, 20'h05555, 1'b0, 1'b0, 3'd0, 20'h0, 1'b0, 1'b0, 1'b1, ar_s, mr_s);
      check_eq("trap_exit_mode", 32'(bus.trap_mode), 32'd0);
      step(1'b1, 3'd5, 20'h05555, 1'b0, 1'b0, 3'd0, 20'h0, 1'b0, 1'b0, 1'b0, ar_s, mr_s);
      check_eq("trap_held_grant", 32'(ar_s), 32'd1);
      check_eq("trap_held_write", 32'(bus.wr_idx), 32'd5);
      idle_step(1'b0, 1'b1);

      // Reset while a write sits on the port: cleared at once, priority back to ALU.
      step(1'b1, 3'd3, 20'h00777, 1'b0, 1'b0, 3'd0, 20'h0, 1'b0, 1'b0, 1'b0, ar_s, mr_s);
      rst_n = 1'b0;
      #1;
      check_eq("rst_async_wr_en", 32'(bus.wr_en), 32'd0);
      apply_reset();
      step(1'b1, 3'd2, 20'h00ABC, 1'b0, 1'b1, 3'd5, 20'h00DEF, 1'b0, 1'b0, 1'b0, ar_s, mr_s);
      check_eq("rst_prio_alu", 32'(ar_s), 32'd1);
      idle_step(1'b0, 1'b0);
      idle_step(1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
